// File: rtl/booth_r4_sequencer_if.sv
// Accumulator-side bus of the Booth multiplier: partial-product drive from the
// sequencer (master) and the running result back from the accumulator (slave).
interface booth_r4_sequencer_if #(
  parameter int OPW = 8
);
  logic [OPW:0]     md;
  logic             cla_sub;
  logic             load;
  logic [2*OPW-1:0] acc_res;

  modport master (
    output md,
    output cla_sub,
    output load,
    input  acc_res
  );

  modport slave (
    input  md,
    input  cla_sub,
    input  load,
    output acc_res
  );
endinterface

// File: rtl/booth_r4_sequencer.sv
// Radix-4 Booth recoder and control FSM for the 8x8 signed accumulator multiplier:
// one recoding step per cycle, result captured from the accumulator at the end.
//
// state | meaning
// IDLE  | waiting for start, accumulator bus quiet
// LOAD  | accumulator cleared at the next edge
// ITER  | one Booth digit per cycle, multiplier shifted right by 2
// CAPT  | accumulator result registered as product, done pulsed
module booth_r4_sequencer #(
  parameter int OPW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OPW-1:0]       mcand,
  input  logic [OPW-1:0]       mplr,
  booth_r4_sequencer_if.master acc,
  output logic                 busy,
  output logic                 done,
  output logic [2*OPW-1:0]     product
);
  localparam int N_ITER = OPW / 2;
  localparam logic [1:0] CNT_LAST = 2'(N_ITER - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ITER = 2'd2;
  localparam logic [1:0] CAPT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [OPW-1:0]   mc_q, mc_d;
  logic [OPW:0]     q_q, q_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*OPW-1:0] product_q, product_d;

  logic [OPW:0]     md_c;
  logic             sub_c;
  logic             load_c;

  always_comb begin
    state_d   = state_q;
    mc_d      = mc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    md_c      = '0;
    sub_c     = 1'b0;
    load_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mc_d    = mcand;
          q_d     = {mplr, 1'b0};
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_c  = 1'b1;
        cnt_d   = 2'd0;
        state_d = ITER;
      end
      ITER: begin
        // Digit taken from {q[2i+1], q[2i], q[2i-1]}; 2M is a plain left shift,
        // which still fits 9 bits for M = -128.
        case (q_q[2:0])
          3'b001, 3'b010: md_c = {mc_q[OPW-1], mc_q};
          3'b011:         md_c = {mc_q, 1'b0};
          3'b100: begin
            md_c  = {mc_q, 1'b0};
            sub_c = 1'b1;
          end
          3'b101, 3'b110: begin
            md_c  = {mc_q[OPW-1], mc_q};
            sub_c = 1'b1;
          end
          default: begin
            md_c  = '0;
            sub_c = 1'b0;
          end
        endcase
        q_d   = {q_q[OPW], q_q[OPW], q_q[OPW:2]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CNT_LAST) state_d = CAPT;
      end
      CAPT: begin
        product_d = acc.acc_res;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mc_q      <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mc_q      <= mc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign acc.md      = md_c;
  assign acc.cla_sub = sub_c;
  assign acc.load    = load_c;
  assign busy        = busy_q;
  assign done        = done_q;
  assign product     = product_q;
endmodule

// File: tb/tb_booth_r4_sequencer.sv
// Bench for booth_r4_sequencer with a behavioural weighted accumulator; products
// are checked by a done-driven scoreboard, bus timing by directed checks.
module tb_booth_r4_sequencer;
  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplr;
  logic        busy;
  logic        done;
  logic [15:0] product;

  booth_r4_sequencer_if #(.OPW(8)) bif ();

  booth_r4_sequencer #(.OPW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplr    (mplr),
    .acc     (bif.master),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator: each non-load cycle adds +/-md weighted by 4^k, k = steps since load.
  logic [15:0] acc_q;
  logic [2:0]  acc_k;

  function automatic logic [15:0] pp_of(logic [8:0] m, logic s, logic [2:0] k);
    logic [15:0] v;
    v = {{7{m[8]}}, m};
    if (s) v = -v;
    return v << {k, 1'b0};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      acc_k <= '0;
    end else if (bif.load) begin
      acc_q <= '0;
      acc_k <= '0;
    end else begin
      acc_q <= acc_q + pp_of(bif.md, bif.cla_sub, acc_k);
      if (acc_k < 3'd4) acc_k <= acc_k + 3'd1;
    end
  end
  assign bif.acc_res = acc_q;

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done cycle pops one expected product.
  initial begin
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        check("done_width", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("product", 32'(product), 32'(exp_q.pop_front()));
      end
      prev_done = done;
    end
  end

  // Drives start for exactly one sampling edge; returns #1 after that edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] e, input bit push);
    @(negedge clk);
    mcand = a;
    mplr  = b;
    start = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_edges, output int edges);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    for (int i = 0; i < max_edges; i++) begin
      @(posedge clk);
      #1;
      edges = i + 1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  logic [8:0] t1_md[4]  = '{9'h003, 9'h003, 9'h000, 9'h000};
  logic       t1_sub[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [8:0] t2_md[4]  = '{9'h000, 9'h000, 9'h000, 9'h100};
  logic       t2_sub[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int          edges;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic signed [15:0] re;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b0;
    start = 1'b0;
    mcand = '0;
    mplr  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_load", 32'(bif.load), 32'd0);
    check("rst_md", 32'(bif.md), 32'd0);
    check("rst_sub", 32'(bif.cla_sub), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 3 * 5: digits +1, +1, 0, 0
    start_op(8'd3, 8'd5, 16'd15, 1'b1);
    check("t1_load", 32'(bif.load), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("t1_md", 32'(bif.md), 32'(t1_md[k]));
      check("t1_sub", 32'(bif.cla_sub), 32'(t1_sub[k]));
    end
    wait_done(10, edges);
    check("t1_latency", 32'(4 + edges), 32'd6);
    check("t1_busy_low", 32'(busy), 32'd0);

    // -128 * -128: last digit -2 gives md = -256 subtracted
    start_op(8'h80, 8'h80, 16'h4000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("t2_md", 32'(bif.md), 32'(t2_md[k]));
      check("t2_sub", 32'(bif.cla_sub), 32'(t2_sub[k]));
    end
    wait_done(10, edges);

    start_op(8'h80, 8'h7f, 16'hC080, 1'b1);
    wait_done(10, edges);
    start_op(8'h00, 8'hff, 16'h0000, 1'b1);
    wait_done(10, edges);

    // start held: accepted every 7 cycles; operand changes while busy are ignored
    @(negedge clk);
    mcand = 8'd5;
    mplr  = 8'd6;
    start = 1'b1;
    exp_q.push_back(16'd30);
    @(posedge clk);
    #1;
    mcand = 8'hf9;
    mplr  = 8'd9;
    exp_q.push_back(16'hFFC1);
    check("thr_busy", 32'(busy), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("thr_done0", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    check("thr_done0_low", 32'(done), 32'd0);
    check("thr_busy1", 32'(busy), 32'd1);
    mcand = 8'd11;
    mplr  = 8'hf4;
    exp_q.push_back(16'hFF7C);
    repeat (6) @(posedge clk);
    #1;
    check("thr_done1", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("thr_done2", 32'(done), 32'd1);
    check("thr_product2", 32'(product), 32'hFF7C);

    // asynchronous reset during ITER aborts the operation
    start_op(8'd100, 8'd3, 16'd0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_load", 32'(bif.load), 32'd0);
    check("ar_md", 32'(bif.md), 32'd0);
    check("ar_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    start_op(8'd7, 8'hf7, 16'hFFC1, 1'b1);
    wait_done(10, edges);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      re = $signed(ra) * $signed(rb);
      start_op(ra, rb, re, 1'b1);
      wait_done(10, edges);
    end

    @(negedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
